id_imm_stage: RTL

Registered, parametrised immediate-generation stage for the ID pipeline. It accepts one 32-bit instruction per cycle under a valid/ready handshake and decodes every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount, optional CSR zimm) with correct sign extension to XLEN. It outputs the immediate, its format and an illegal-encoding flag one cycle later. A two-entry skid buffer gives full throughput under downstream backpressure, and a synchronous flush supports branch redirect.

---
 rtl/id_pkg.sv | 35 +++
 rtl/id_imm_extract.sv | 117 +++++++++++
 rtl/id_imm_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the ID-stage immediate generator: format codes and
// the RV32I/RV64I major opcodes it recognises.
package id_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_Z     = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD       = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM   = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
    localparam logic [6:0] OPC_STORE      = 7'b0100011;
    localparam logic [6:0] OPC_OP         = 7'b0110011;
    localparam logic [6:0] OPC_LUI        = 7'b0110111;
    localparam logic [6:0] OPC_OP_32      = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
    localparam logic [6:0] OPC_JALR       = 7'b1100111;
    localparam logic [6:0] OPC_JAL        = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM     = 7'b1110011;

    // Shift-immediate forms of OP-IMM / OP-IMM-32 are selected by funct3.
    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/id_imm_extract.sv
// Combinational immediate decoder for RV32I/RV64I instruction words.
// Define IMMGEN_CSR_EN to decode the CSR zimm field of SYSTEM instructions.
module id_imm_extract
    import id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("id_imm_extract: XLEN must be 32 or 64");
    end

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        shift;
    logic [31:0] raw;
    logic        sext;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign shift  = is_shift_funct3(funct3);

    // raw is built already sign-extended to 32 bits; sext chooses how it widens to XLEN.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        raw     = '0;
        sext    = 1'b0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
                fmt  = FMT_I;
                sext = 1'b1;
                raw  = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_OP_IMM: begin
                if (shift) begin
                    if (!RV64 && instr[25]) begin
                        illegal = 1'b1;
                    end else begin
                        fmt = FMT_SHAMT;
                        raw = RV64 ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
                    end
                end else begin
                    fmt  = FMT_I;
                    sext = 1'b1;
                    raw  = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_OP_IMM_32: begin
                if (!RV64) begin
                    illegal = 1'b1;
                end else if (shift) begin
                    fmt = FMT_SHAMT;
                    raw = {27'b0, instr[24:20]};
                end else begin
                    fmt  = FMT_I;
                    sext = 1'b1;
                    raw  = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_STORE: begin
                fmt  = FMT_S;
                sext = 1'b1;
                raw  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt  = FMT_B;
                sext = 1'b1;
                raw  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt  = FMT_U;
                sext = 1'b1;
                raw  = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt  = FMT_J;
                sext = 1'b1;
                raw  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP: begin
                fmt = FMT_NONE;
            end
            OPC_OP_32: begin
                illegal = !RV64;
            end
            OPC_SYSTEM: begin
`ifdef IMMGEN_CSR_EN
                if (funct3 inside {3'b101, 3'b110, 3'b111}) begin
                    fmt = FMT_Z;
                    raw = {27'b0, instr[19:15]};
                end
`endif
            end
            default: begin
                // Also catches every word whose low two bits are not 2'b11.
                illegal = 1'b1;
            end
        endcase
    end

    logic [XLEN-1:0] imm_signed;
    logic [XLEN-1:0] imm_unsigned;

    assign imm_signed   = XLEN'($signed(raw));
    assign imm_unsigned = XLEN'(raw);
    assign imm          = sext ? imm_signed : imm_unsigned;

endmodule

// File: rtl/id_imm_stage.sv
// Registered immediate-generation stage: one output register plus a skid
// register behind a valid/ready handshake. Optional IMMGEN_CSR_EN enables zimm decode.
module id_imm_stage
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output imm_fmt_e         o_fmt,
    output logic             o_illegal,
    output logic [31:0]      o_instr,
    output logic [TAG_W-1:0] o_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    id_imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .instr   (i_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    entry_t new_entry;
    entry_t out_q;
    entry_t skid_q;
    logic   out_valid_q;
    logic   skid_valid_q;
    logic   in_fire;
    logic   out_free;

    assign new_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal,
                         instr: i_instr, tag: i_tag};

    // o_ready comes straight from a flop, so the upstream path stays short.
    assign o_ready  = !skid_valid_q;
    assign in_fire  = i_valid && o_ready;
    assign out_free = !out_valid_q || i_ready;

    // in_fire and a full skid register are mutually exclusive because o_ready
    // is low whenever the skid register holds an entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the datapath registers are reset too so the outputs read zero after reset.
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (i_flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // NOTE: non-blocking assignments let this read the old skid value.
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_fire;
                if (in_fire) begin
                    out_q <= new_entry;
                end
            end
        end else if (in_fire) begin
            skid_q       <= new_entry;
            skid_valid_q <= 1'b1;
        end
    end

    assign o_valid   = out_valid_q;
    assign o_imm     = out_q.imm;
    assign o_fmt     = out_q.fmt;
    assign o_illegal = out_q.illegal;
    assign o_instr   = out_q.instr;
    assign o_tag     = out_q.tag;

endmodule
